prescaler_scheduler: RTL and testbench

- Timer scheduler layered on a prescaler-style base divider.
- Derives one base tick from `clk_in` and services 4 programmable tick-count channels.
- One shared decrement/compare datapath is sequenced round-robin by an FSM, once per tick.
- Emits per-channel expiry pulses and square-wave toggles; software programs channels through a valid/ready config port.

---
 rtl/prescaler_scheduler.sv | 158 +++++++++++++++
 tb/tb_prescaler_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/prescaler_scheduler.sv
// -----------------------------------------------------------------------------
// prescaler_scheduler
//   A base divider produces one tick every DIV = MAIN_CLOCK/TICK_HZ cycles.
//   Each tick, a 4-slot round-robin scan drives one shared decrement/compare
//   datapath across four programmable tick-count channels. Each channel has
//   a reload period, a down-counter, a one-shot flag and an active bit.
//
//   state | meaning
//   ------+--------------------------------------------
//   IDLE  | waiting for base tick; config port open
//   SCAN0 | service channel 0
//   SCAN1 | service channel 1
//   SCAN2 | service channel 2
//   SCAN3 | service channel 3, then back to IDLE
//
// Ports
//   clk_in      : system clock, all logic on posedge
//   rst         : asynchronous active-low reset
//   cfg_valid   : config request
//   cfg_ready   : config accept (IDLE and no tick this cycle)
//   cfg_ch      : target channel index
//   cfg_period  : reload period in ticks, 0 disables the channel
//   cfg_enable  : channel enable
//   cfg_oneshot : fire once then self-disable
//   tick_out    : one-cycle base tick strobe
//   ch_pulse    : one-cycle expiry pulse per channel
//   ch_toggle   : per-channel square wave, inverts on each expiry
//   ch_active   : per-channel enable state
// -----------------------------------------------------------------------------
module prescaler_scheduler #(
    parameter int MAIN_CLOCK = 50_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int PERIOD_W   = 16
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_enable,
    input  logic                cfg_oneshot,
    output logic                tick_out,
    output logic [3:0]          ch_pulse,
    output logic [3:0]          ch_toggle,
    output logic [3:0]          ch_active
);

    localparam int                DIV      = MAIN_CLOCK / TICK_HZ;
    localparam logic [31:0]       DIV_LAST = 32'(DIV - 1);
    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

    // A scan takes 4 cycles; DIV >= 8 guarantees a tick never lands mid-scan.
    generate
        if (DIV < 8) begin : g_div_check
            $error("prescaler_scheduler: MAIN_CLOCK/TICK_HZ must be >= 8");
        end
    endgenerate

    // Bit 2 marks a scan state and bits [1:0] give the channel being serviced.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN0 = 3'd4;
    localparam logic [2:0] S_SCAN1 = 3'd5;
    localparam logic [2:0] S_SCAN2 = 3'd6;
    localparam logic [2:0] S_SCAN3 = 3'd7;

    logic [31:0]         r_base_cnt;
    logic                r_tick;
    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [PERIOD_W-1:0] r_count  [4];
    logic [PERIOD_W-1:0] r_period [4];
    logic [3:0]          r_oneshot;
    logic [3:0]          r_active;
    logic [3:0]          r_toggle;
    logic [3:0]          r_pulse;
    logic                w_scanning;
    logic [1:0]          w_slot;
    logic                w_cfg_fire;

    assign w_scanning = r_state[2];
    assign w_slot     = r_state[1:0];
    // rst term holds ready low while reset is asserted (state is already IDLE then).
    assign cfg_ready  = (r_state == S_IDLE) && !r_tick && rst;
    assign w_cfg_fire = cfg_valid && cfg_ready;

    assign tick_out  = r_tick;
    assign ch_pulse  = r_pulse;
    assign ch_toggle = r_toggle;
    assign ch_active = r_active;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_base_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_base_cnt == DIV_LAST) begin
            r_base_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_base_cnt <= r_base_cnt + 32'd1;
            r_tick     <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_tick) w_state_nxt = S_SCAN0;
            S_SCAN0: w_state_nxt = S_SCAN1;
            S_SCAN1: w_state_nxt = S_SCAN2;
            S_SCAN2: w_state_nxt = S_SCAN3;
            S_SCAN3: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Config and scan never coincide: cfg_ready is only high in IDLE.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                r_count[k]  <= '0;
                r_period[k] <= '0;
            end
            r_oneshot <= '0;
            r_active  <= '0;
            r_toggle  <= '0;
            r_pulse   <= '0;
        end else begin
            r_pulse <= '0;
            if (w_cfg_fire) begin
                r_period[cfg_ch]  <= cfg_period;
                r_count[cfg_ch]   <= cfg_period;
                r_oneshot[cfg_ch] <= cfg_oneshot;
                r_active[cfg_ch]  <= cfg_enable && (cfg_period != '0);
            end else if (w_scanning && r_active[w_slot]) begin
                if (r_count[w_slot] == CNT_ONE) begin
                    r_count[w_slot]  <= r_period[w_slot];
                    r_pulse[w_slot]  <= 1'b1;
                    r_toggle[w_slot] <= ~r_toggle[w_slot];
                    if (r_oneshot[w_slot]) begin
                        r_active[w_slot] <= 1'b0;
                    end
                end else if (r_count[w_slot] > CNT_ONE) begin
                    r_count[w_slot] <= r_count[w_slot] - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_prescaler_scheduler.sv
// -----------------------------------------------------------------------------
// tb_prescaler_scheduler
//   Directed bench for prescaler_scheduler with DIV = 1000/100 = 10.
//   Cycle index c counts rising edges since reset release; outputs are
//   sampled 1 ns after each edge. Expected pulse/active timelines are
//   written out by hand from the configuration schedule below.
// -----------------------------------------------------------------------------
module tb_prescaler_scheduler;

    logic        clk_in;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_enable;
    logic        cfg_oneshot;
    logic        tick_out;
    logic [3:0]  ch_pulse;
    logic [3:0]  ch_toggle;
    logic [3:0]  ch_active;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] m_tog;

    prescaler_scheduler #(
        .MAIN_CLOCK(1000),
        .TICK_HZ   (100),
        .PERIOD_W  (16)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_enable (cfg_enable),
        .cfg_oneshot(cfg_oneshot),
        .tick_out   (tick_out),
        .ch_pulse   (ch_pulse),
        .ch_toggle  (ch_toggle),
        .ch_active  (ch_active)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Schedule: ch0 P=3 accepted at edge 46, ch3 P=2 oneshot at 76,
    // ch1 P=1 at 106 (held across tick 100), ch2 P=0 at 116.
    function automatic logic [3:0] exp_pulse(input int c);
        logic [3:0] p;
        p = 4'b0000;
        p[0] = (c >= 72)  && ((c - 72) % 30 == 0);
        p[1] = (c >= 113) && ((c - 113) % 10 == 0);
        p[3] = (c == 95);
        return p;
    endfunction

    function automatic logic [3:0] exp_active(input int c);
        logic [3:0] a;
        a = 4'b0000;
        a[0] = (c >= 46);
        a[1] = (c >= 106);
        a[3] = (c >= 76) && (c < 95);
        return a;
    endfunction

    function automatic logic exp_tick(input int c);
        return (c > 0) && (c % 10 == 0);
    endfunction

    function automatic logic exp_ready(input int c);
        return (c < 10) || (c % 10 >= 5);
    endfunction

    task automatic check_cycle(input int c, input logic [3:0] ep, input logic [3:0] ea,
                               input logic [3:0] et);
        chk($sformatf("tick c=%0d", c),   {3'b000, tick_out},  {3'b000, exp_tick(c)});
        chk($sformatf("ready c=%0d", c),  {3'b000, cfg_ready}, {3'b000, exp_ready(c)});
        chk($sformatf("pulse c=%0d", c),  ch_pulse,  ep);
        chk($sformatf("active c=%0d", c), ch_active, ea);
        chk($sformatf("toggle c=%0d", c), ch_toggle, et);
    endtask

    task automatic drive_cfg(input logic v, input logic [1:0] ch, input logic [15:0] per,
                             input logic en, input logic os);
        cfg_valid   = v;
        cfg_ch      = ch;
        cfg_period  = per;
        cfg_enable  = en;
        cfg_oneshot = os;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " tick"},   {3'b000, tick_out},  4'h0);
        chk({tag, " ready"},  {3'b000, cfg_ready}, 4'h0);
        chk({tag, " pulse"},  ch_pulse,  4'h0);
        chk({tag, " active"}, ch_active, 4'h0);
        chk({tag, " toggle"}, ch_toggle, 4'h0);
    endtask

    initial begin
        rst = 1'b0;
        drive_cfg(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
        m_tog = 4'b0000;
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("in_reset");
        rst = 1'b1;

        for (int c = 1; c <= 322; c++) begin
            @(posedge clk_in);
            #1;
            m_tog = m_tog ^ exp_pulse(c);
            check_cycle(c, exp_pulse(c), exp_active(c), m_tog);
            if (c == 321) begin
                chk("toggle_before_reset", ch_toggle, 4'b1011);
            end
            case (c)
                45:  drive_cfg(1'b1, 2'd0, 16'd3, 1'b1, 1'b0);
                75:  drive_cfg(1'b1, 2'd3, 16'd2, 1'b1, 1'b1);
                100: drive_cfg(1'b1, 2'd1, 16'd1, 1'b1, 1'b0);
                115: drive_cfg(1'b1, 2'd2, 16'd0, 1'b1, 1'b0);
                46, 76, 106, 116: drive_cfg(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
                default: ;
            endcase
        end

        // c=322 is SCAN1 of the tick at 320, with ch0 and ch1 active.
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) begin
            @(posedge clk_in);
            #1;
            check_all_zero("held_reset");
        end
        rst = 1'b1;
        m_tog = 4'b0000;

        for (int c = 1; c <= 30; c++) begin
            @(posedge clk_in);
            #1;
            check_cycle(c, 4'b0000, 4'b0000, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
